// File: rtl/alu_struct.sv
// alu_struct: 8-bit registered ALU with 16-bit result and 4-bit status (C,Z,N,V).
// Datapath is structural: shared ripple adder/subtractor, logic unit,
// optional array multiplier, and an output mux feeding the result/SREG registers.
// Optional feature macro: ALU_MUL_EN (instantiates the multiplier for op 0).
// Timing: operands and select are sampled every rising clk; result and SREG
// appear one cycle later. There is no valid/ready handshake: every edge is an issue.
module alu_struct (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] res_hi,
    output logic [7:0] res_lo,
    output logic [3:0] SREG,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] function_select_lines
);

    localparam logic [3:0] OP_MUL = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_INC = 4'd3;
    localparam logic [3:0] OP_DEC = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;

    logic [7:0] res_hi_q, res_hi_d;
    logic [7:0] res_lo_q, res_lo_d;
    logic [3:0] sreg_q, sreg_d;

    // ---------------- shared ripple adder/subtractor ----------------
    // SUB adds ~B with carry-in 1; INC adds 0 with carry-in 1; DEC adds 0xFF.
    logic [7:0] add_y;
    logic       add_cin;
    logic [7:0] add_sum;
    logic [8:0] carry;
    logic       add_ovf;

    // Select the second adder operand and carry-in for the arithmetic op.
    always_comb begin
        add_y   = B;
        add_cin = 1'b0;
        case (function_select_lines)
            OP_SUB:  begin add_y = ~B;    add_cin = 1'b1; end
            OP_INC:  begin add_y = 8'h00; add_cin = 1'b1; end
            OP_DEC:  begin add_y = 8'hFF; add_cin = 1'b0; end
            default: begin add_y = B;     add_cin = 1'b0; end
        endcase
    end

    assign carry[0] = add_cin;
    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign add_sum[i]   = A[i] ^ add_y[i] ^ carry[i];
        assign carry[i+1]   = (A[i] & add_y[i]) | (carry[i] & (A[i] ^ add_y[i]));
    end

    // Signed overflow on the effective operands covers ADD/SUB and the
    // 0x7F/0x80 boundaries of INC/DEC.
    assign add_ovf = (A[7] == add_y[7]) && (add_sum[7] != A[7]);

    // ---------------- logic unit ----------------
    logic [7:0] and_r, or_r, xor_r, not_r;
    assign and_r = A & B;
    assign or_r  = A | B;
    assign xor_r = A ^ B;
    assign not_r = ~A;

`ifdef ALU_MUL_EN
    // ---------------- array multiplier ----------------
    // Each row adds one shifted partial product to the running sum.
    logic [15:0] pp_sum [0:8];
    logic [15:0] product;
    assign pp_sum[0] = 16'h0000;
    for (genvar r = 0; r < 8; r++) begin : g_mul_row
        assign pp_sum[r+1] = pp_sum[r] + ({8'h00, (A & {8{B[r]}})} << r);
    end
    assign product = pp_sum[8];
`endif

    // ---------------- output mux / flag generation ----------------
    logic [7:0] r8;
    logic       r8_valid;

    // Pick the 8-bit result and compute next result/SREG; SREG holds by default.
    always_comb begin
        res_hi_d = 8'h00;
        res_lo_d = 8'h00;
        sreg_d   = sreg_q;
        r8       = 8'h00;
        r8_valid = 1'b1;
        case (function_select_lines)
            OP_ADD: begin r8 = add_sum; sreg_d[0] = carry[8];  sreg_d[3] = add_ovf; end
            OP_SUB: begin r8 = add_sum; sreg_d[0] = ~carry[8]; sreg_d[3] = add_ovf; end
            OP_INC: begin r8 = add_sum; sreg_d[3] = add_ovf; end
            OP_DEC: begin r8 = add_sum; sreg_d[3] = add_ovf; end
            OP_AND: begin r8 = and_r;   sreg_d[3] = 1'b0; end
            OP_OR:  begin r8 = or_r;    sreg_d[3] = 1'b0; end
            OP_XOR: begin r8 = xor_r;   sreg_d[3] = 1'b0; end
            OP_NOT: begin r8 = not_r;   sreg_d[0] = 1'b1; sreg_d[3] = 1'b0; end
            default: r8_valid = 1'b0;
        endcase
        if (r8_valid) begin
            res_lo_d  = r8;
            sreg_d[1] = (r8 == 8'h00);
            sreg_d[2] = r8[7];
        end
`ifdef ALU_MUL_EN
        if (function_select_lines == OP_MUL) begin
            {res_hi_d, res_lo_d} = product;
            sreg_d = {1'b0, 1'b0, (product == 16'h0000), product[15]};
        end
`endif
    end

    // Result and status registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_hi_q <= 8'h00;
            res_lo_q <= 8'h00;
            sreg_q   <= 4'h0;
        end else begin
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            sreg_q   <= sreg_d;
        end
    end

    assign res_hi = res_hi_q;
    assign res_lo = res_lo_q;
    assign SREG   = sreg_q;

endmodule

// File: tb/tb_alu_struct.sv
// Testbench for alu_struct: directed vectors with hand-computed expectations,
// scoreboard queue of {res_hi,res_lo,SREG}, monitor compares one cycle after issue.
module tb_alu_struct;
    localparam int W = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] res_hi, res_lo;
    logic [3:0] SREG;
    logic [7:0] A = 8'h00, B = 8'h00;
    logic [3:0] fsel = 4'h0;
    logic       issue_v = 1'b0;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    alu_struct dut (
        .clk(clk), .rst(rst),
        .res_hi(res_hi), .res_lo(res_lo), .SREG(SREG),
        .A(A), .B(B), .function_select_lines(fsel)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got res=%h sreg=%h, expected res=%h sreg=%h",
                     name, act[19:4], act[3:0], exp[19:4], exp[3:0]);
        end
    endtask

    // ---------------- driver ----------------
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic [15:0] exp_res, input logic [3:0] exp_sreg);
        @(negedge clk);
        A = a; B = b; fsel = op; issue_v = 1'b1;
        exp_q.push_back({exp_res, exp_sreg});
    endtask

    task automatic idle();
        @(negedge clk);
        issue_v = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin : monitor
        logic v;
        logic [W-1:0] e;
        v = issue_v && !rst;
        #1;
        if (v) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {res_hi, res_lo, SREG}, {W{1'b0}});
            end else begin
                e = exp_q.pop_front();
                check("scoreboard", {res_hi, res_lo, SREG}, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        #2 rst = 1'b1;
        #1 check("reset_async", {res_hi, res_lo, SREG}, {W{1'b0}});
        @(posedge clk); #1;
        check("reset_held", {res_hi, res_lo, SREG}, {W{1'b0}});
        @(negedge clk); rst = 1'b0;

        issue(8'd6,   8'd9,   4'd1, 16'h000F, 4'h0);
        issue(8'd3,   8'd6,   4'd2, 16'h00FD, 4'h5);
        issue(8'd127, 8'd125, 4'd3, 16'h0080, 4'hD);
        issue(8'd1,   8'd2,   4'd4, 16'h0000, 4'h3);
`ifdef ALU_MUL_EN
        issue(8'd1,   8'd2,   4'd0, 16'h0002, 4'h0);
        issue(8'hFF,  8'hFF,  4'd0, 16'hFE01, 4'h1);
`else
        issue(8'd1,   8'd2,   4'd0, 16'h0000, 4'h3);
        issue(8'hFF,  8'hFF,  4'd0, 16'h0000, 4'h3);
`endif
        issue(8'd5,   8'd5,   4'd5, 16'h0005, 4'h1);
        issue(8'd13,  8'd85,  4'd6, 16'h005D, 4'h1);
        issue(8'd13,  8'd85,  4'd7, 16'h0058, 4'h1);
        issue(8'd13,  8'd85,  4'd8, 16'h00F2, 4'h5);
        issue(8'd13,  8'd85,  4'd12, 16'h0000, 4'h5);
        issue(8'h80,  8'h80,  4'd1, 16'h0000, 4'hB);
        issue(8'h80,  8'h01,  4'd2, 16'h007F, 4'h8);
        issue(8'h80,  8'h01,  4'd15, 16'h0000, 4'h8);
`ifdef ALU_MUL_EN
        issue(8'd3,   8'd4,   4'd0, 16'h000C, 4'h0);
`else
        issue(8'd3,   8'd4,   4'd0, 16'h0000, 4'h8);
`endif
        issue(8'hF0,  8'h0F,  4'd5, 16'h0000, 4'h2);
        issue(8'h7F,  8'h01,  4'd1, 16'h0080, 4'hC);
        idle();

        // Reset in the middle of an ADD: outputs clear at once, op is discarded.
        @(negedge clk);
        A = 8'h10; B = 8'h20; fsel = 4'd1; issue_v = 1'b0;
        #2 rst = 1'b1;
        #1 check("reset_mid_op", {res_hi, res_lo, SREG}, {W{1'b0}});
        @(posedge clk); #1;
        check("reset_over_edge", {res_hi, res_lo, SREG}, {W{1'b0}});
        @(negedge clk); rst = 1'b0;

        issue(8'h00, 8'h00, 4'd3, 16'h0001, 4'h0);
        issue(8'h80, 8'h00, 4'd4, 16'h007F, 4'h8);
        issue(8'h00, 8'h00, 4'd4, 16'h00FF, 4'h4);
        idle();
        repeat (3) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
